// File: rtl/uart_rx_param_driver_pkg.sv
// Shared constants and types for the parametrised UART receiver (and the
// future parametrised transmitter).
package uart_rx_param_driver_pkg;

    localparam int BYTE_LEN    = 8;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_rx_param_driver_sampler.sv
// Input conditioning for the receiver: two-flop synchroniser on rxd, a
// three-deep history of the synchronised line and a 2-of-3 majority vote.
module uart_rx_sampler
    import uart_rx_param_driver_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    output logic rxd_s,
    output logic maj
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [2:0] hist_q, hist_d;

    // Next-value logic: shift rxd through the synchroniser and the history.
    always_comb begin
        sync1_d = rxd;
        sync2_d = sync1_q;
        hist_d  = {hist_q[1:0], sync2_q};
    end

    // Registers reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 3'b111;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign rxd_s = sync2_q;
    assign maj   = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_param_driver.sv
// Parametrised oversampling UART receiver.
//
// state       | meaning
// S_IDLE      | line idle, waiting for a low level
// S_START     | confirming the start bit at its centre
// S_DATA      | sampling DATA_BITS data bits, LSB first
// S_PARITY    | sampling the parity bit
// S_STOP      | sampling STOP_BITS stop bits
// S_DONE      | results registered, out_ready asserted for this cycle
// S_WAIT_HIGH | after a framing error, waiting for the line to go high
module uart_rx_param_driver
    import uart_rx_param_driver_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 434,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] out,
    output logic                 out_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 brk,
    output logic                 busy
);

    localparam int CNT_W = clog2(CYCLES_PER_BIT) + 1;
    localparam int IDX_W = clog2(DATA_BITS) + 1;

    localparam logic [CNT_W-1:0] HALF_TC   = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TC    = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    if (CYCLES_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_rx_param_driver: unsupported parameter combination");
    end

    logic rxd_s;
    logic maj;

    uart_rx_sampler u_sampler (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .rxd_s (rxd_s),
        .maj   (maj)
    );

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 stop0_q, stop0_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;

    // Final-frame flag values, valid on the last stop-bit sample.
    logic fe_final;
    logic first_stop;
    logic par_odd_ones;

    // Next-state and datapath logic for the receive sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop0_d    = stop0_q;
        ferr_acc_d = ferr_acc_q;
        out_d      = out_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;

        fe_final     = ferr_acc_q | ~maj;
        first_stop   = (idx_q == '0) ? maj : stop0_q;
        par_odd_ones = (^shift_q) ^ par_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_TC) begin
                    if (maj) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        cnt_d      = '0;
                        idx_d      = '0;
                        ferr_acc_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_TC) begin
                    cnt_d   = '0;
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == BIT_TC) begin
                    cnt_d   = '0;
                    par_d   = maj;
                    idx_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_TC) begin
                    cnt_d      = '0;
                    idx_d      = idx_q + IDX_W'(1);
                    ferr_acc_d = fe_final;
                    if (idx_q == '0) begin
                        stop0_d = maj;
                    end
                    if (idx_q == LAST_STOP) begin
                        state_d = S_DONE;
                        out_d   = shift_q;
                        ferr_d  = fe_final;
                        if (PARITY_MODE == PARITY_EVEN) begin
                            perr_d = par_odd_ones;
                        end else if (PARITY_MODE == PARITY_ODD) begin
                            perr_d = ~par_odd_ones;
                        end else begin
                            perr_d = 1'b0;
                        end
                        brk_d = fe_final & (shift_q == '0) & ~first_stop &
                                ((PARITY_MODE == PARITY_NONE) | ~par_q);
                    end
                end
            end
            S_DONE: begin
                state_d = ferr_q ? S_WAIT_HIGH : S_IDLE;
            end
            S_WAIT_HIGH: begin
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop0_q    <= 1'b1;
            ferr_acc_q <= 1'b0;
            out_q      <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop0_q    <= stop0_d;
            ferr_acc_q <= ferr_acc_d;
            out_q      <= out_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    assign out        = out_q;
    assign out_ready  = (state_q == S_DONE);
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign brk        = brk_q;
    assign busy       = (state_q != S_IDLE);

endmodule
